// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake bundle for the iterative AES-128 inverse cipher:
// ciphertext/key in on one valid/ready pair, plaintext out on another.
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;

    modport master (
        output in_valid, ct_in, key_in, out_ready,
        input  in_ready, out_valid, pt_out
    );

    modport slave (
        input  in_valid, ct_in, key_in, out_ready,
        output in_ready, out_valid, pt_out
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, with round
// keys derived on the fly by running the key schedule backwards.
module aes_inv_cipher_iter #(
    parameter int NR           = 10,
    parameter bit CLEAR_ON_POP = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_inv_cipher_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv_sub_byte(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte index is 4*column + row; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_column(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                a[w]  = s[127-32*c-8*w -: 8];
                x2    = xt(a[w]);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[w] = x8 ^ a[w];
                mb[w] = x8 ^ x2 ^ a[w];
                md[w] = x8 ^ x4 ^ a[w];
                me[w] = x8 ^ x4 ^ x2;
            end
            r[127-32*c -: 32] = {
                me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]
            };
        end
        return r;
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Round-i key in, round-(i-1) key out.
    function automatic logic [127:0] invkey(input logic [127:0] k,
                                            input logic [3:0]   i);
        logic [31:0] t0, t1, t2, t3;
        t3 = k[31:0]   ^ k[63:32];
        t2 = k[63:32]  ^ k[95:64];
        t1 = k[95:64]  ^ k[127:96];
        t0 = k[127:96] ^ sbox_word({t3[23:0], t3[31:24]}) ^ {rcon(i), 24'h0};
        return {t0, t1, t2, t3};
    endfunction

    state_t       state, state_nx;
    logic [127:0] st, rk, pt;
    logic [3:0]   rnd;
    logic [127:0] sub_sh, round_out, final_out;

    assign sub_sh    = inv_sub_bytes(inv_shift_rows(st));
    assign final_out = sub_sh ^ rk;
    assign round_out = inv_mix_column(final_out);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = ROUND;
            ROUND:   if (rnd == 4'd1) state_nx = FINAL;
            FINAL:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.pt_out    = pt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= '0;
            rk  <= '0;
            rnd <= '0;
            pt  <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    st  <= bus.ct_in ^ bus.key_in;
                    rk  <= invkey(bus.key_in, 4'(NR));
                    rnd <= 4'(NR - 1);
                end
                ROUND: begin
                    st  <= round_out;
                    rk  <= invkey(rk, rnd);
                    rnd <= rnd - 4'd1;
                end
                FINAL: pt <= final_out;
                DONE: if (bus.out_ready && CLEAR_ON_POP) pt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS vectors plus a forward-cipher
// reference model feeding a scoreboard of expected plaintexts.
module tb_aes_inv_cipher_iter;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter #(
        .NR(10),
        .CLEAR_ON_POP(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int last_acc = 0;
    int acc_q[$];
    logic [127:0] sb[$];
    logic [127:0] exp_next = '0;
    logic prev_ov = 1'b0;
    logic [7:0] sbt [256];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(exp_next);
                last_acc = cyc + 1;
                acc_q.push_back(cyc + 1);
            end
            if (bus.out_valid && !prev_ov)
                check("latency", 128'(cyc - last_acc), 128'd10);
            if (bus.out_valid && bus.out_ready) begin
                check("sb_depth", 128'(sb.size()), 128'd1);
                if (sb.size() > 0) check("pt_out", bus.pt_out, sb.pop_front());
                pops++;
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbt[x] = b;
        end
    endtask

    task automatic enc(input logic [127:0] pt, input logic [127:0] key,
                       output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] s, t;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]],
                       sbt[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[8*i +: 8] = sbt[s[8*i +: 8]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[127-8*(4*c+q) -: 8] = t[127-8*(4*((c+q)%4)+q) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 32] = {
                        gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                        a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                        a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                        gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)
                    };
                end
            end
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        ct = s;
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] exp);
        int k;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            step();
            k++;
        end
        bus.ct_in = ct;
        bus.key_in = key;
        exp_next = exp;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while (pops < n && k < budget) begin
            step();
            k++;
        end
        check("pop_wait", 128'(pops >= n), 128'd1);
    endtask

    task automatic wait_ov(input string tag);
        int k;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            step();
            k++;
        end
        check(tag, 128'(bus.out_valid), 128'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] mct, mk10, hold_pt, rpt, rkey;
        logic ok;
        int base;
        bus.in_valid = 1'b0;
        bus.ct_in = '0;
        bus.key_in = '0;
        bus.out_ready = 1'b1;
        build_sbox();

        enc(C1_PT, C1_KEY, mct, mk10);
        check("model_c1_ct", mct, C1_CT);
        check("model_c1_k10", mk10, C1_K10);

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_pt", bus.pt_out, 128'd0);
        rst_n = 1'b1;

        send(C1_CT, C1_K10, C1_PT);
        wait_pops(1, 40);
        send(B_CT, B_K10, B_PT);
        wait_pops(2, 40);

        bus.out_ready = 1'b0;
        send(C1_CT, C1_K10, C1_PT);
        wait_ov("bp_ov_rise");
        hold_pt = bus.pt_out;
        ok = 1'b1;
        repeat (20) begin
            step();
            if (!(bus.out_valid && bus.pt_out == hold_pt && !bus.in_ready))
                ok = 1'b0;
        end
        check("bp_hold", 128'(ok), 128'd1);
        check("bp_pt", bus.pt_out, C1_PT);
        check("bp_in_ready", 128'(bus.in_ready), 128'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp_pop_ready", 128'(bus.in_ready), 128'd1);
        wait_pops(3, 5);

        send(C1_CT, C1_K10, C1_PT);
        bus.ct_in = '1;
        exp_next = '1;
        bus.in_valid = 1'b1;
        wait_ov("busy_ov_rise");
        bus.ct_in = B_CT;
        bus.key_in = B_K10;
        exp_next = B_PT;
        begin
            int k;
            k = 0;
            while (!bus.in_ready && k < 10) begin
                step();
                k++;
            end
        end
        step();
        bus.in_valid = 1'b0;
        wait_pops(5, 40);
        check("busy_spacing", 128'(acc_q[$] - acc_q[$-1]), 128'd12);

        send(C1_CT, C1_K10, C1_PT);
        repeat (4) step();
        bus.ct_in = C1_CT;
        bus.key_in = C1_K10;
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        step();
        check("mid_rst_ov", 128'(bus.out_valid), 128'd0);
        check("mid_rst_pt", bus.pt_out, 128'd0);
        check("mid_rst_rdy", 128'(bus.in_ready), 128'd1);
        rst_n = 1'b1;
        exp_next = C1_PT;
        step();
        bus.in_valid = 1'b0;
        check("rst_hold_accept", 128'(acc_q[$]), 128'(cyc));
        wait_pops(6, 40);

        base = acc_q.size();
        for (int b = 0; b < 8; b++) begin
            rpt = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            enc(rpt, rkey, mct, mk10);
            send(mct, mk10, rpt);
        end
        wait_pops(14, 200);
        for (int b = 1; b < 8; b++)
            check("b2b_spacing", 128'(acc_q[base+b] - acc_q[base+b-1]), 128'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
